ana_peak_pipe: RTL and testbench

- Parametrised successor of the frame spectrum analyser.
- Accepts one frame of N complex FFT bins in parallel through a valid/ready handshake, then scans the bins one per cycle.
- For each bin it computes the magnitude squared (re² + im²) in a pipelined datapath and reports the index and magnitude of the peak bin.
- Adds threshold detection and optional DC-bin exclusion; sits between the FFT core and the system result/control logic.

---
 rtl/ana_peak_pipe.sv | 173 +++++++++++++++++
 tb/tb_ana_peak_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ana_peak_pipe.sv
// ana_peak_pipe
// -------------
// Peak-bin finder for one frame of N_BIN complex FFT bins. A frame is taken
// in parallel through a valid/ready handshake. The bins are then scanned one
// per cycle through a two-stage pipeline: stage 1 computes |X|^2 and stage 2
// keeps a running maximum. The index and magnitude of the peak bin are
// reported together with a threshold-hit flag.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   frame present on in_data
//   in_ready   block can accept a frame (high only in IDLE)
//   in_data    bin k at [k*2*DW +: 2*DW]; real = upper DW bits, imag = lower
//   thresh     unsigned detection threshold, captured at accept
//   ignore_dc  exclude bin 0 from the search, captured at accept
//   done       one-cycle pulse when freq/peak_mag/peak_hit update
//   freq       index of the peak bin (lowest index on ties)
//   peak_mag   re^2 + im^2 of the peak bin
//   peak_hit   peak_mag >= captured threshold
//
// Handshake: a frame transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the registered state, never on in_valid. While
// in_ready is low, in_valid is ignored and upstream keeps holding the frame.
//
// Timing, with accept at edge A: edges A+1..A+N_BIN shift the frame and fill
// stage 1; edge A+N_BIN+1 (DRAIN) does the last compare and returns to IDLE;
// edge A+N_BIN+2 publishes the results and pulses done. A new frame can be
// accepted on that same edge, so one frame completes every N_BIN+2 cycles.
// The internal 'state' register is the FSM state for debug and checker binding.
module ana_peak_pipe #(
    parameter int N_BIN = 16,
    parameter int DW    = 16,
    localparam int IW   = $clog2(N_BIN),
    localparam int MW   = 2 * DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_BIN*2*DW-1:0]  in_data,
    input  logic [MW-1:0]          thresh,
    input  logic                   ignore_dc,
    output logic                   done,
    output logic [IW-1:0]          freq,
    output logic [MW-1:0]          peak_mag,
    output logic                   peak_hit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_BIN = IW'(N_BIN - 1);

    state_t                  state;
    logic [N_BIN*2*DW-1:0]   frame_q;
    logic [IW-1:0]           cnt;
    logic [MW-1:0]           thresh_q;
    logic                    ign_q;

    // Stage 1: magnitude of the bin currently at position 0 of the buffer.
    logic                    s1_v;
    logic [IW-1:0]           s1_idx;
    logic [MW-1:0]           s1_mag;

    // Stage 2: running maximum. have_max makes the first eligible bin win
    // even when its magnitude is zero (matters for all-zero frames with DC
    // excluded, where the answer must be bin 1, not the cleared index 0).
    logic                    have_max;
    logic [MW-1:0]           max_mag;
    logic [IW-1:0]           max_idx;

    logic                    rpt;
    logic                    accept;

    logic [DW-1:0]           re_c;
    logic [DW-1:0]           im_c;
    logic [MW-1:0]           re_x;
    logic [MW-1:0]           im_x;
    logic [MW-1:0]           mag_c;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Sign-extend to MW bits and keep the low MW bits of the product: the
    // true square is below 2^(MW-2)+1, so the truncated product is exact and
    // the sum of two squares peaks at exactly 2^(MW-1) without overflow.
    assign re_c  = frame_q[2*DW-1:DW];
    assign im_c  = frame_q[DW-1:0];
    assign re_x  = {{DW{re_c[DW-1]}}, re_c};
    assign im_x  = {{DW{im_c[DW-1]}}, im_c};
    assign mag_c = (re_x * re_x) + (im_x * im_x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            frame_q  <= '0;
            cnt      <= '0;
            thresh_q <= '0;
            ign_q    <= 1'b0;
            s1_v     <= 1'b0;
            s1_idx   <= '0;
            s1_mag   <= '0;
            have_max <= 1'b0;
            max_mag  <= '0;
            max_idx  <= '0;
            rpt      <= 1'b0;
            done     <= 1'b0;
            freq     <= '0;
            peak_mag <= '0;
            peak_hit <= 1'b0;
        end else begin
            rpt  <= 1'b0;
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        frame_q  <= in_data;
                        thresh_q <= thresh;
                        ign_q    <= ignore_dc;
                        cnt      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    frame_q <= frame_q >> (2 * DW);
                    cnt     <= cnt + IW'(1);
                    if (cnt == LAST_BIN) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    rpt   <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Stage 1 is loaded only on SCAN edges; the DC bin is marked
            // invalid here so it can never reach the compare stage.
            s1_v   <= (state == SCAN) && !(ign_q && (cnt == '0));
            s1_mag <= mag_c;
            s1_idx <= cnt;

            // Stage 2: strict greater-than keeps the lowest index on ties
            // because bins arrive in ascending order.
            if (accept) begin
                have_max <= 1'b0;
                max_mag  <= '0;
                max_idx  <= '0;
            end else if (s1_v && (!have_max || (s1_mag > max_mag))) begin
                have_max <= 1'b1;
                max_mag  <= s1_mag;
                max_idx  <= s1_idx;
            end

            // Results come from the max registers of the finished frame.
            // A same-edge accept clears those registers and reloads thresh_q
            // only after this read.
            if (rpt) begin
                done     <= 1'b1;
                freq     <= max_idx;
                peak_mag <= max_mag;
                peak_hit <= (max_mag >= thresh_q);
            end
        end
    end

endmodule

// File: tb/tb_ana_peak_pipe.sv
module tb_ana_peak_pipe;
    localparam int N_BIN = 16;
    localparam int DW    = 16;
    localparam int IW    = 4;
    localparam int MW    = 32;
    localparam int FW    = N_BIN * 2 * DW;
    localparam int LAT   = N_BIN + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [FW-1:0]  in_data;
    logic [MW-1:0]  thresh;
    logic           ignore_dc;
    logic           done;
    logic [IW-1:0]  freq;
    logic [MW-1:0]  peak_mag;
    logic           peak_hit;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Current frame as plain signed integers, one entry per bin.
    int re_a[N_BIN];
    int im_a[N_BIN];

    ana_peak_pipe #(.N_BIN(N_BIN), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .thresh    (thresh),
        .ignore_dc (ignore_dc),
        .done      (done),
        .freq      (freq),
        .peak_mag  (peak_mag),
        .peak_hit  (peak_hit)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- frame helpers ----------------
    function automatic logic [FW-1:0] pack_frame();
        logic [FW-1:0] v;
        logic [15:0]   r;
        logic [15:0]   i;
        v = '0;
        for (int k = 0; k < N_BIN; k++) begin
            r = 16'(re_a[k]);
            i = 16'(im_a[k]);
            v[k*32 +: 32] = {r, i};
        end
        return v;
    endfunction

    task automatic clear_frame();
        for (int k = 0; k < N_BIN; k++) begin
            re_a[k] = 0;
            im_a[k] = 0;
        end
    endtask

    task automatic fill_frame(input int lo, input int hi);
        for (int k = 0; k < N_BIN; k++) begin
            re_a[k] = int'($urandom_range(0, hi - lo)) + lo;
            im_a[k] = int'($urandom_range(0, hi - lo)) + lo;
        end
    endtask

    // Reference: largest |X|^2 over eligible bins, then the first bin holding it.
    task automatic model(input logic ign, input logic [MW-1:0] thr,
                         output logic [IW-1:0] f, output logic [MW-1:0] m, output logic h);
        longint mags[N_BIN];
        longint best;
        int     first;
        best  = -1;
        first = -1;
        for (int k = 0; k < N_BIN; k++) begin
            mags[k] = longint'(re_a[k]) * longint'(re_a[k]) + longint'(im_a[k]) * longint'(im_a[k]);
            if (!(ign && k == 0) && mags[k] > best) best = mags[k];
        end
        for (int k = N_BIN - 1; k >= 0; k--) begin
            if (!(ign && k == 0) && mags[k] == best) first = k;
        end
        f = IW'(first);
        m = best[MW-1:0];
        h = (best >= longint'(thr));
    endtask

    // ---------------- driver ----------------
    // Presents the current frame, waits (bounded) for acceptance, then keeps
    // in_valid high with junk data and junk thresh/ignore_dc during the scan.
    // Observes: done latency (edges after accept), ready violations, pulses.
    task automatic run_frame(input logic [MW-1:0] thr, input logic ign,
                             output bit acc_ok, output int lat, output int ready_bad,
                             output int done_cnt, output logic [IW-1:0] f,
                             output logic [MW-1:0] m, output logic h);
        acc_ok = 1'b0; lat = -1; ready_bad = 0; done_cnt = 0;
        f = '0; m = '0; h = 1'b0;
        @(negedge clk);
        in_data = pack_frame(); thresh = thr; ignore_dc = ign; in_valid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            if (in_ready === 1'b1) begin
                acc_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc_ok) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int k = 0; k <= N_BIN + 4; k++) begin
            @(negedge clk);
            if (k <= N_BIN && in_ready !== 1'b0) ready_bad++;
            if (k == N_BIN + 1 && in_ready !== 1'b1) ready_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    f = freq; m = peak_mag; h = peak_hit;
                end
            end
            if (k < N_BIN) begin
                for (int j = 0; j < FW / 32; j++) in_data[j*32 +: 32] = $urandom();
                thresh    = $urandom();
                ignore_dc = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n_done;
        int n_busy;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; thresh = '0; ignore_dc = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (freq !== '0) begin n_errors++; $display("FAIL reset_freq: got %0d want 0", freq); end
        n_checks++; if (peak_mag !== '0) begin n_errors++; $display("FAIL reset_peak_mag: got %0d want 0", peak_mag); end
        n_checks++; if (peak_hit !== 1'b0) begin n_errors++; $display("FAIL reset_peak_hit: got %b want 0", peak_hit); end
        rst = 1'b1;
        n_done = 0; n_busy = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done !== 1'b0) n_done++;
            if (in_ready !== 1'b1) n_busy++;
        end
        n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL idle_no_done: got %0d pulses want 0", n_done); end
        n_checks++; if (n_busy != 0) begin n_errors++; $display("FAIL idle_ready: got %0d low cycles want 0", n_busy); end
    endtask

    // One frame from the current arrays, compared against the model.
    task automatic test_frame(input string name, input logic [MW-1:0] thr, input logic ign);
        logic [IW-1:0] ef, af;
        logic [MW-1:0] em, am;
        logic          eh, ah;
        bit            acc_ok;
        int            lat, ready_bad, done_cnt;
        model(ign, thr, ef, em, eh);
        run_frame(thr, ign, acc_ok, lat, ready_bad, done_cnt, af, am, ah);
        n_checks++;
        if (!acc_ok) begin
            n_errors++; $display("FAIL %s accept: in_ready never high within 50 cycles", name);
            return;
        end
        n_checks++; if (lat != LAT) begin n_errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); end
        n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt); end
        n_checks++; if (ready_bad != 0) begin n_errors++; $display("FAIL %s in_ready_timing: got %0d bad cycles want 0", name, ready_bad); end
        n_checks++; if (af !== ef) begin n_errors++; $display("FAIL %s freq: got %0d want %0d", name, af, ef); end
        n_checks++; if (am !== em) begin n_errors++; $display("FAIL %s peak_mag: got 0x%08h want 0x%08h", name, am, em); end
        n_checks++; if (ah !== eh) begin n_errors++; $display("FAIL %s peak_hit: got %b want %b", name, ah, eh); end
    endtask

    task automatic test_single();
        for (int k = 0; k < N_BIN; k++) begin re_a[k] = 10; im_a[k] = 10; end
        re_a[5] = 300; im_a[5] = -400;
        test_frame("single", 32'd200000, 1'b0);
    endtask

    task automatic test_tie_extreme();
        clear_frame();
        im_a[3] = -1000; im_a[9] = -1000;
        test_frame("tie_thr_equal", 32'd1000000, 1'b0);
        test_frame("tie_thr_above", 32'd1000001, 1'b0);
        fill_frame(-200, 200);
        re_a[15] = -32768; im_a[15] = -32768;
        test_frame("extreme", 32'hFFFF_FFFF, 1'b0);
        test_frame("extreme_hit", 32'h8000_0000, 1'b0);
    endtask

    task automatic test_dc();
        clear_frame();
        re_a[0] = 5000; re_a[7] = 100;
        test_frame("dc_excluded", 32'd10000, 1'b1);
        test_frame("dc_included", 32'd30000000, 1'b0);
        clear_frame();
        test_frame("zero_dc_excl", 32'd0, 1'b1);
        test_frame("zero_dc_incl", 32'd1, 1'b0);
    endtask

    task automatic test_random();
        logic [IW-1:0] ef;
        logic [MW-1:0] em, thr;
        logic          eh, ign;
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 1) == 1) fill_frame(-32768, 32767);
            else fill_frame(-300, 300);
            if ($urandom_range(0, 2) == 0) begin
                int a, b;
                a = int'($urandom_range(0, N_BIN - 1));
                b = int'($urandom_range(0, N_BIN - 1));
                re_a[b] = re_a[a]; im_a[b] = -im_a[a];
            end
            ign = 1'($urandom_range(0, 1));
            model(ign, '0, ef, em, eh);
            case ($urandom_range(0, 3))
                0: thr = em;
                1: thr = em + 32'd1;
                2: thr = '0;
                default: thr = $urandom();
            endcase
            test_frame($sformatf("random%0d", t), thr, ign);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] f1, f2;
        logic [IW-1:0] exp_q[$];
        logic [IW-1:0] ef;
        logic [MW-1:0] em;
        logic          eh;
        int            acc_e[$];
        int            done_e[$];
        int            n_acc;
        fill_frame(-100, 100); re_a[2] = 700; im_a[2] = 700;
        f1 = pack_frame(); model(1'b0, '0, ef, em, eh); exp_q.push_back(ef);
        fill_frame(-100, 100); re_a[12] = -900; im_a[12] = 50;
        f2 = pack_frame(); model(1'b0, '0, ef, em, eh); exp_q.push_back(ef);
        @(negedge clk);
        in_data = f1; thresh = '0; ignore_dc = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            n_acc = 0;
            foreach (acc_e[i]) if (acc_e[i] <= edge_n) n_acc++;
            if (n_acc == 1) in_data = f2;
            if (n_acc >= 2) in_valid = 1'b0;
            if (done === 1'b1) begin
                done_e.push_back(edge_n);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL b2b_extra_done: done at edge %0d with no frame pending", edge_n);
                end else begin
                    ef = exp_q.pop_front();
                    if (freq !== ef) begin n_errors++; $display("FAIL b2b_freq: got %0d want %0d", freq, ef); end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) acc_e.push_back(edge_n + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (acc_e.size() != 2) begin n_errors++; $display("FAIL b2b_accepts: got %0d want 2", acc_e.size()); end
        n_checks++; if (done_e.size() != 2) begin n_errors++; $display("FAIL b2b_dones: got %0d want 2", done_e.size()); end
        if (acc_e.size() == 2 && done_e.size() == 2) begin
            n_checks++; if (acc_e[1] - acc_e[0] != LAT) begin n_errors++; $display("FAIL b2b_accept_gap: got %0d want %0d", acc_e[1] - acc_e[0], LAT); end
            n_checks++; if (done_e[0] - acc_e[0] != LAT) begin n_errors++; $display("FAIL b2b_first_latency: got %0d want %0d", done_e[0] - acc_e[0], LAT); end
            n_checks++; if (done_e[1] - done_e[0] != LAT) begin n_errors++; $display("FAIL b2b_done_gap: got %0d want %0d", done_e[1] - done_e[0], LAT); end
        end
    endtask

    task automatic test_reset_mid_scan();
        bit acc_ok;
        int n_done;
        fill_frame(-100, 100); re_a[10] = 20000;
        @(negedge clk);
        in_data = pack_frame(); thresh = '0; ignore_dc = 1'b0; in_valid = 1'b1;
        acc_ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            if (in_ready === 1'b1) begin acc_ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!acc_ok) begin
            n_errors++; $display("FAIL midrst_accept: in_ready never high within 50 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (freq !== '0) begin n_errors++; $display("FAIL midrst_freq: got %0d want 0", freq); end
        n_checks++; if (peak_mag !== '0) begin n_errors++; $display("FAIL midrst_peak_mag: got %0d want 0", peak_mag); end
        n_checks++; if (peak_hit !== 1'b0) begin n_errors++; $display("FAIL midrst_peak_hit: got %b want 0", peak_hit); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || peak_mag !== '0) n_done++;
        end
        n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL midrst_aborted: got %0d cycles with done/outputs set want 0", n_done); end
        fill_frame(-100, 100); re_a[4] = 3000; im_a[4] = -3000;
        test_frame("after_reset", 32'd1000, 1'b0);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_tie_extreme();
        test_dc();
        test_random();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
